operand_forward_stage: RTL and testbench

OPERAND_FORWARD_STAGE -- requirements
Module: operand_forward_stage

---
 rtl/operand_forward_stage.sv | 142 ++++++++++++++
 tb/tb_operand_forward_stage.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/operand_forward_stage.sv
// ID/EX operand forwarding stage: selects forwarded operands, inserts a single load-use bubble,
// and keeps saturating counts of forwarded captures and load-use stall cycles.
module operand_forward_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  ForwardToMux5,
  input  logic [2:0]  ForwardToMux3,
  input  logic        HazardDetected,
  input  logic [15:0] RegData1,
  input  logic [15:0] RegData2,
  input  logic [15:0] MEMResult1,
  input  logic [15:0] MEMResult2,
  input  logic [15:0] WBResult1,
  input  logic [15:0] WBResult2,
  input  logic        MemIsLoad,
  input  logic        InValid,
  input  logic        Flush,
  input  logic        ExHold,
  output logic [15:0] OperandA,
  output logic [15:0] OperandB,
  output logic        OutValid,
  output logic        StallIFID,
  output logic [15:0] ForwardCount,
  output logic [7:0]  StallCount
);

  typedef enum logic [0:0] {StRun, StLstall} state_e;

  state_e      state_q, state_d;
  logic [15:0] opa_q, opa_d;
  logic [15:0] opb_q, opb_d;
  logic        valid_q, valid_d;
  logic [15:0] fwd_cnt_q, fwd_cnt_d;
  logic [7:0]  stall_cnt_q, stall_cnt_d;
  logic        stall;
  logic        capture;

  // Forwarding flag is informational only; selection is fully decoded from the mux selects.
  logic unused_hazard;
  assign unused_hazard = HazardDetected;

  function automatic logic [15:0] fwd_mux(input logic [2:0]  sel,
                                          input logic [15:0] reg_data,
                                          input logic [15:0] mem1,
                                          input logic [15:0] mem2,
                                          input logic [15:0] wb1,
                                          input logic [15:0] wb2);
    logic [15:0] res;
    case (sel)
      3'b001:  res = mem1;
      3'b010:  res = mem2;
      3'b011:  res = wb1;
      3'b100:  res = wb2;
      default: res = reg_data;
    endcase
    return res;
  endfunction

  logic [15:0] mux_a, mux_b;
  logic        sel_a_mem, sel_b_mem, sel_a_fwd, sel_b_fwd, load_use;

  assign mux_a = fwd_mux(ForwardToMux5, RegData1, MEMResult1, MEMResult2, WBResult1, WBResult2);
  assign mux_b = fwd_mux(ForwardToMux3, RegData2, MEMResult1, MEMResult2, WBResult1, WBResult2);

  assign sel_a_mem = (ForwardToMux5 == 3'b001) || (ForwardToMux5 == 3'b010);
  assign sel_b_mem = (ForwardToMux3 == 3'b001) || (ForwardToMux3 == 3'b010);
  assign sel_a_fwd = (ForwardToMux5 >= 3'b001) && (ForwardToMux5 <= 3'b100);
  assign sel_b_fwd = (ForwardToMux3 >= 3'b001) && (ForwardToMux3 <= 3'b100);
  assign load_use  = InValid && MemIsLoad && (sel_a_mem || sel_b_mem);

  always_comb begin
    state_d     = state_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    valid_d     = valid_q;
    fwd_cnt_d   = fwd_cnt_q;
    stall_cnt_d = stall_cnt_q;
    stall       = 1'b0;
    capture     = 1'b0;

    if (Flush) begin
      valid_d = 1'b0;
      state_d = StRun;
    end else if (ExHold) begin
      stall = 1'b1;
    end else begin
      unique case (state_q)
        StRun: begin
          if (load_use) begin
            stall   = 1'b1;
            valid_d = 1'b0;
            state_d = StLstall;
            if (stall_cnt_q != 8'hFF) stall_cnt_d = stall_cnt_q + 8'd1;
          end else begin
            capture = 1'b1;
          end
        end
        // Load data is now in WB; capture without re-checking so one bubble per instruction.
        StLstall: begin
          capture = 1'b1;
          state_d = StRun;
        end
        default: state_d = StRun;
      endcase
    end

    if (capture) begin
      opa_d   = mux_a;
      opb_d   = mux_b;
      valid_d = InValid;
      if (InValid && (sel_a_fwd || sel_b_fwd) && (fwd_cnt_q != 16'hFFFF)) begin
        fwd_cnt_d = fwd_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StRun;
      opa_q       <= 16'h0000;
      opb_q       <= 16'h0000;
      valid_q     <= 1'b0;
      fwd_cnt_q   <= 16'h0000;
      stall_cnt_q <= 8'h00;
    end else begin
      state_q     <= state_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      valid_q     <= valid_d;
      fwd_cnt_q   <= fwd_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign OperandA     = opa_q;
  assign OperandB     = opb_q;
  assign OutValid     = valid_q;
  assign StallIFID    = stall && rst_n;
  assign ForwardCount = fwd_cnt_q;
  assign StallCount   = stall_cnt_q;

endmodule

// File: tb/tb_operand_forward_stage.sv
// Self-checking bench for operand_forward_stage: vector table plus hand-built sequences for
// counter saturation and reset during a load-use stall, checked through a scoreboard queue.
module tb_operand_forward_stage;

  localparam logic [15:0] R1 = 16'h1111;
  localparam logic [15:0] R2 = 16'h2222;
  localparam logic [15:0] M1 = 16'h00AA;
  localparam logic [15:0] M2 = 16'h4444;
  localparam logic [15:0] W2 = 16'hBEEF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  sel5, sel3;
  logic        hazard, mem_is_load, in_valid, flush, ex_hold;
  logic [15:0] reg1, reg2, mem1, mem2, wb1, wb2;
  logic [15:0] opa, opb, fwd_cnt;
  logic        out_valid, stall_ifid;
  logic [7:0]  stall_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [2:0]  s5;
    logic [2:0]  s3;
    logic        hz;
    logic        iv;
    logic        ml;
    logic        fl;
    logic        eh;
    logic [15:0] w1;
    logic [15:0] ea;
    logic [15:0] eb;
    logic        ev;
    logic        est;
    logic [15:0] efc;
    logic [7:0]  esc;
  } vec_t;

  vec_t sb[$];
  vec_t tbl[21];

  always #5 clk = ~clk;

  operand_forward_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ForwardToMux5 (sel5),
    .ForwardToMux3 (sel3),
    .HazardDetected(hazard),
    .RegData1      (reg1),
    .RegData2      (reg2),
    .MEMResult1    (mem1),
    .MEMResult2    (mem2),
    .WBResult1     (wb1),
    .WBResult2     (wb2),
    .MemIsLoad     (mem_is_load),
    .InValid       (in_valid),
    .Flush         (flush),
    .ExHold        (ex_hold),
    .OperandA      (opa),
    .OperandB      (opb),
    .OutValid      (out_valid),
    .StallIFID     (stall_ifid),
    .ForwardCount  (fwd_cnt),
    .StallCount    (stall_cnt)
  );

  function automatic vec_t mkv(input logic [2:0] s5, input logic [2:0] s3, input logic hz,
                               input logic iv, input logic ml, input logic fl, input logic eh,
                               input logic [15:0] w1, input logic [15:0] ea,
                               input logic [15:0] eb, input logic ev, input logic est,
                               input logic [15:0] efc, input logic [7:0] esc);
    vec_t v;
    v.s5 = s5; v.s3 = s3; v.hz = hz; v.iv = iv; v.ml = ml; v.fl = fl; v.eh = eh;
    v.w1 = w1; v.ea = ea; v.eb = eb; v.ev = ev; v.est = est; v.efc = efc; v.esc = esc;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [15:0] act,
                     input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s [%0d]: got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  // Drive one cycle of stimulus, check the combinational stall, then score the registered result.
  task automatic step(input vec_t v, input int idx);
    vec_t e;
    sel5 = v.s5; sel3 = v.s3; hazard = v.hz; in_valid = v.iv; mem_is_load = v.ml;
    flush = v.fl; ex_hold = v.eh; wb1 = v.w1;
    #1;
    chk("stall_ifid", idx, {15'd0, stall_ifid}, {15'd0, v.est});
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("operand_a", idx, opa, e.ea);
    chk("operand_b", idx, opb, e.eb);
    chk("out_valid", idx, {15'd0, out_valid}, {15'd0, e.ev});
    chk("forward_count", idx, fwd_cnt, e.efc);
    chk("stall_count", idx, {8'd0, stall_cnt}, {8'd0, e.esc});
  endtask

  task automatic chk_reset_outputs(input int idx);
    chk("rst_operand_a", idx, opa, 16'h0000);
    chk("rst_operand_b", idx, opb, 16'h0000);
    chk("rst_out_valid", idx, {15'd0, out_valid}, 16'h0000);
    chk("rst_forward_count", idx, fwd_cnt, 16'h0000);
    chk("rst_stall_count", idx, {8'd0, stall_cnt}, 16'h0000);
    chk("rst_stall_ifid", idx, {15'd0, stall_ifid}, 16'h0000);
  endtask

  initial begin
    logic [15:0] ea_m, eb_m, fc_m;
    logic [7:0]  sc_m;

    //            s5 s3 hz iv ml fl eh  w1        ea        eb        ev est fc      sc
    tbl[0]  = mkv(0, 0, 0, 1, 0, 0, 0, 16'h5555, R1,       R2,       1, 0, 16'd0, 8'd0);
    tbl[1]  = mkv(0, 0, 1, 1, 0, 0, 0, 16'h5555, R1,       R2,       1, 0, 16'd0, 8'd0);
    tbl[2]  = mkv(3, 4, 0, 1, 0, 0, 0, 16'h5555, 16'h5555, W2,       1, 0, 16'd1, 8'd0);
    tbl[3]  = mkv(1, 2, 0, 1, 0, 0, 0, 16'h5555, M1,       M2,       1, 0, 16'd2, 8'd0);
    tbl[4]  = mkv(4, 3, 0, 1, 0, 0, 0, 16'h5555, W2,       16'h5555, 1, 0, 16'd3, 8'd0);
    tbl[5]  = mkv(5, 6, 0, 1, 0, 0, 0, 16'h5555, R1,       R2,       1, 0, 16'd3, 8'd0);
    tbl[6]  = mkv(7, 7, 0, 1, 0, 0, 0, 16'h5555, R1,       R2,       1, 0, 16'd3, 8'd0);
    tbl[7]  = mkv(3, 0, 0, 0, 0, 0, 0, 16'h5555, 16'h5555, R2,       0, 0, 16'd3, 8'd0);
    tbl[8]  = mkv(4, 0, 0, 0, 1, 0, 0, 16'h5555, W2,       R2,       0, 0, 16'd3, 8'd0);
    tbl[9]  = mkv(1, 0, 0, 1, 1, 0, 0, 16'h5555, W2,       R2,       0, 1, 16'd3, 8'd1);
    tbl[10] = mkv(3, 0, 0, 1, 1, 0, 0, 16'h00AA, 16'h00AA, R2,       1, 0, 16'd4, 8'd1);
    tbl[11] = mkv(1, 0, 0, 1, 1, 1, 0, 16'h5555, 16'h00AA, R2,       0, 0, 16'd4, 8'd1);
    tbl[12] = mkv(2, 0, 0, 1, 1, 0, 0, 16'h5555, 16'h00AA, R2,       0, 1, 16'd4, 8'd2);
    tbl[13] = mkv(0, 0, 0, 1, 0, 0, 0, 16'h5555, R1,       R2,       1, 0, 16'd4, 8'd2);
    tbl[14] = mkv(3, 4, 0, 1, 0, 0, 1, 16'h1234, R1,       R2,       1, 1, 16'd4, 8'd2);
    tbl[15] = mkv(1, 2, 1, 1, 1, 0, 1, 16'h9876, R1,       R2,       1, 1, 16'd4, 8'd2);
    tbl[16] = mkv(4, 1, 0, 0, 0, 0, 1, 16'h4321, R1,       R2,       1, 1, 16'd4, 8'd2);
    tbl[17] = mkv(3, 4, 0, 1, 0, 0, 0, 16'h1234, 16'h1234, W2,       1, 0, 16'd5, 8'd2);
    tbl[18] = mkv(0, 2, 0, 1, 1, 0, 0, 16'h5555, 16'h1234, W2,       0, 1, 16'd5, 8'd3);
    tbl[19] = mkv(0, 2, 0, 1, 1, 0, 0, 16'h5555, R1,       M2,       1, 0, 16'd6, 8'd3);
    tbl[20] = mkv(3, 0, 0, 1, 1, 1, 1, 16'h5555, R1,       M2,       0, 0, 16'd6, 8'd3);

    reg1 = R1; reg2 = R2; mem1 = M1; mem2 = M2; wb1 = 16'h5555; wb2 = W2;
    // Reset with a stall-provoking input pattern: outputs and StallIFID must still read zero.
    rst_n = 1'b0; sel5 = 3'd1; sel3 = 3'd0; hazard = 1'b0; mem_is_load = 1'b1;
    in_valid = 1'b1; flush = 1'b0; ex_hold = 1'b1;
    #2;
    chk_reset_outputs(0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 21; i++) step(tbl[i], i);

    ea_m = R1; eb_m = M2; fc_m = 16'd6; sc_m = 8'd3;

    for (int i = 0; fc_m != 16'hFFFF; i++) begin
      fc_m = fc_m + 16'd1;
      ea_m = i[15:0] ^ 16'h5A5A;
      eb_m = R2;
      step(mkv(3, 0, 0, 1, 0, 0, 0, ea_m, ea_m, eb_m, 1, 0, fc_m, sc_m), 100);
    end
    step(mkv(3, 0, 0, 1, 0, 0, 0, 16'h7777, 16'h7777, R2, 1, 0, 16'hFFFF, sc_m), 101);
    ea_m = 16'h7777;

    while (sc_m != 8'hFF) begin
      sc_m = sc_m + 8'd1;
      step(mkv(1, 0, 0, 1, 1, 0, 0, 16'h0000, ea_m, eb_m, 0, 1, fc_m, sc_m), 200);
      ea_m = R1; eb_m = R2;
      step(mkv(0, 0, 0, 1, 0, 0, 0, 16'h0000, ea_m, eb_m, 1, 0, fc_m, sc_m), 201);
    end
    step(mkv(2, 0, 0, 1, 1, 0, 0, 16'h0000, ea_m, eb_m, 0, 1, fc_m, 8'hFF), 202);

    // Now in the stall state: asynchronous reset must clear everything immediately.
    ex_hold = 1'b1;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs(300);
    #1;
    rst_n = 1'b1;
    ex_hold = 1'b0;
    step(mkv(1, 0, 0, 1, 1, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 1, 16'd0, 8'd1), 301);
    step(mkv(0, 0, 0, 1, 0, 0, 0, 16'h0000, R1, R2, 1, 0, 16'd0, 8'd1), 302);

    chk("scoreboard_empty", 303, 16'(sb.size()), 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
